bp_me_stream_rr_arbiter: RTL and testbench
==========================================

// Module: bp_me_stream_rr_arbiter
// PURPOSE
//  Round-robin arbiter for BedRock mem_fwd streams: header + data + last per beat.
//  Shares one device-side mem_fwd sink among num_source_p requesters,
//  e.g. the L2 cache slice fed by the CCE and an I/O/DMA path.
//  A grant holds from a stream's first beat until its last beat is accepted.
//  A credit counter caps messages that have been issued but whose response has not retired.
// PARAMETERS
//  num_source_p      2   number of requesting streams (>=2)
//  header_width_p    64  packed bp_bedrock_mem_fwd_header_s width
//  data_width_p      64  beat data width (bedrock_data_width_p)
//  max_outstanding_p 4   max issued-but-unretired messages (>=1)
// PORTS
//  clk_i          in   1                                clock, all state rises on posedge
//  reset_i        in   1                                synchronous, active-high reset
//  msg_header_i   in   num_source_p*header_width_p      per-source header
//  msg_data_i     in   num_source_p*data_width_p        per-source beat data
//  msg_v_i        in   num_source_p                     per-source beat valid
//  msg_last_i     in   num_source_p                     per-source last beat of message
//  msg_ready_and_o out num_source_p                     per-source ready (ready&valid)
//  msg_header_o   out  header_width_p                   granted header
//  msg_data_o     out  data_width_p                     granted data
//  msg_v_o        out  1                                granted beat valid
//  msg_last_o     out  1                                granted last
//  msg_ready_and_i in  1                                sink ready
//  msg_src_o      out  clog2(num_source_p)              id of granted source (valid when msg_v_o)
//  rev_done_i     in   1                                one response fully retired (rev last handshake)
//  outstanding_o  out  clog2(max_outstanding_p+1)       current credit-in-use count
// BEHAVIOUR
//  - Zero-latency combinational datapath: msg_*_o = mux(msg_*_i, grant).
//  - msg_ready_and_o[grant] = msg_ready_and_i & grant valid; all other bits are 0.
//  - FSM e_idle / e_locked.
//  - e_idle: candidates = msg_v_i, masked to 0 when outstanding==max_outstanding_p.
//    Grant the first candidate at or after rr_ptr (wrapping).
//    msg_v_o=0 if there is no candidate.
//    First-beat handshake (v & ready) with last=0 -> e_locked, grant registered.
//    First-beat handshake with last=1 (single-beat message) -> stay e_idle.
//  - e_locked: the grant is fixed and ignores credits and other sources.
//    The last-beat handshake -> e_idle.
//    Valid bubbles from the granted source do not release the lock.
//  - rr_ptr <= (grant+1) mod num_source_p, updated on the last-beat handshake only.
//  - Credits: +1 on each first-beat handshake, -1 on rev_done_i.
//    If both happen in the same cycle, the count is unchanged.
//    A first beat is never issued at count==max.
//    rev_done_i at count==0 is illegal: assertion, and the count saturates at 0.
//  - A header/source change while locked is a protocol violation (assertion).
//    Inputs must hold while v & ~ready.
//  - Reset: state=e_idle, rr_ptr=0, outstanding_o=0.
//    During and right after reset, msg_v_o=0, msg_ready_and_o=0, msg_src_o=0.
//    Reset in mid-stream drops the lock; sources must restart their messages.
// TESTING
//  1. Src0 and src1 both valid, 1-beat msgs, ready=1, max=4
//     -> grants alternate 0,1,0,1; outstanding_o reaches 4, then msg_v_o=0.
//  2. Src0 sends a 4-beat msg while src1 is valid
//     -> msg_src_o=0 for all 4 beats; src1 is granted on the cycle after last.
//  3. Sink ready toggles 1,0,1 mid-stream -> no beat lost or duplicated; lock holds.
//  4. Count==4, then rev_done_i=1 -> count 3 next cycle, and a pending header issues.
//     A first beat together with rev_done_i -> count stays.
//  5. Reset asserted on beat 2 of a 3-beat msg
//     -> next cycle msg_v_o=0, outstanding_o=0, rr_ptr=0; a new msg from src1 is granted.
//  6. rev_done_i at count 0 -> assertion fires, and outstanding_o stays 0.

Source files
------------

// File: rtl/bp_me_stream_rr_arbiter.sv
// Round-robin arbiter sharing one BedRock mem_fwd sink among several streams.
// A grant is held from a message's first beat to its last; a credit count caps unretired messages.
module bp_me_stream_rr_arbiter #(
  parameter int unsigned num_source_p      = 2,
  parameter int unsigned header_width_p    = 64,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned max_outstanding_p = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_source_p*header_width_p-1:0]   msg_header_i,
  input  logic [num_source_p*data_width_p-1:0]     msg_data_i,
  input  logic [num_source_p-1:0]                  msg_v_i,
  input  logic [num_source_p-1:0]                  msg_last_i,
  output logic [num_source_p-1:0]                  msg_ready_and_o,
  output logic [header_width_p-1:0]                msg_header_o,
  output logic [data_width_p-1:0]                  msg_data_o,
  output logic                                     msg_v_o,
  output logic                                     msg_last_o,
  input  logic                                     msg_ready_and_i,
  output logic [$clog2(num_source_p)-1:0]          msg_src_o,
  input  logic                                     rev_done_i,
  output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o
);

  localparam int unsigned src_w = $clog2(num_source_p);
  localparam int unsigned cnt_w = $clog2(max_outstanding_p + 1);

  typedef enum logic {e_idle, e_locked} state_e;

  state_e                    state_r;
  logic [src_w-1:0]          grant_r;
  logic [src_w-1:0]          rr_ptr_r;
  logic [cnt_w-1:0]          outstanding_r;
  logic [header_width_p-1:0] lock_hdr_r;

  logic                      full;
  logic [num_source_p-1:0]   cand;
  logic [src_w-1:0]          rr_grant;
  logic                      rr_found;
  logic [src_w-1:0]          grant;
  logic                      grant_v;
  logic                      hs;
  logic                      first_hs;
  logic                      last_hs;
  logic                      dec;

  assign full = (outstanding_r == cnt_w'(max_outstanding_p));
  assign cand = full ? '0 : msg_v_i;

  // First candidate at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    rr_grant = '0;
    rr_found = 1'b0;
    idx      = 0;
    for (int i = 0; i < int'(num_source_p); i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= int'(num_source_p)) idx = idx - int'(num_source_p);
      if (!rr_found && cand[idx]) begin
        rr_found = 1'b1;
        rr_grant = src_w'(idx);
      end
    end
  end

  assign grant   = (state_r == e_locked) ? grant_r : rr_grant;
  assign grant_v = (state_r == e_locked) ? msg_v_i[grant_r] : rr_found;

  // Zero-latency datapath, blanked while reset is held.
  always_comb begin
    msg_ready_and_o = '0;
    msg_v_o         = grant_v & ~reset_i;
    msg_header_o    = msg_header_i[int'(grant)*header_width_p +: header_width_p];
    msg_data_o      = msg_data_i[int'(grant)*data_width_p +: data_width_p];
    msg_last_o      = msg_last_i[grant];
    msg_src_o       = msg_v_o ? grant : '0;
    if (msg_v_o) msg_ready_and_o[grant] = msg_ready_and_i;
  end

  assign hs       = msg_v_o & msg_ready_and_i;
  assign first_hs = hs & (state_r == e_idle);
  assign last_hs  = hs & msg_last_o;
  assign dec      = rev_done_i & (outstanding_r != '0);

  assign outstanding_o = outstanding_r;

  // Lock FSM, round-robin pointer and credit counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= e_idle;
      grant_r       <= '0;
      rr_ptr_r      <= '0;
      outstanding_r <= '0;
      lock_hdr_r    <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          if (first_hs && !msg_last_o) begin
            state_r    <= e_locked;
            grant_r    <= grant;
            lock_hdr_r <= msg_header_o;
          end
        end
        e_locked: begin
          if (last_hs) state_r <= e_idle;
        end
        default: state_r <= e_idle;
      endcase
      if (last_hs) begin
        rr_ptr_r <= (int'(grant) == int'(num_source_p) - 1) ? '0 : grant + src_w'(1);
      end
      if (first_hs && !dec) begin
        outstanding_r <= outstanding_r + cnt_w'(1);
      end else if (!first_hs && dec) begin
        outstanding_r <= outstanding_r - cnt_w'(1);
      end
    end
  end

  // Protocol checks: retiring with no credit in use, header drift inside a locked message.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(rev_done_i && outstanding_r == '0))
        else $warning("rev_done_i with no outstanding message; count held at 0");
      assert (!(state_r == e_locked && msg_v_i[grant_r] && msg_header_o != lock_hdr_r))
        else $error("header changed inside a locked message");
    end
  end

endmodule

// File: tb/tb_bp_me_stream_rr_arbiter.sv
// Scoreboard bench for bp_me_stream_rr_arbiter: directed streams, monitor checks every accepted beat.
module tb_bp_me_stream_rr_arbiter;

  localparam int unsigned NS = 2;
  localparam int unsigned HW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MAXO = 4;

  typedef struct packed {
    logic [0:0]    src;
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [NS*HW-1:0]  msg_header_i;
  logic [NS*DW-1:0]  msg_data_i;
  logic [NS-1:0]     msg_v_i;
  logic [NS-1:0]     msg_last_i;
  logic [NS-1:0]     msg_ready_and_o;
  logic [HW-1:0]     msg_header_o;
  logic [DW-1:0]     msg_data_o;
  logic              msg_v_o;
  logic              msg_last_o;
  logic              msg_ready_and_i;
  logic [0:0]        msg_src_o;
  logic              rev_done_i;
  logic [2:0]        outstanding_o;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  bp_me_stream_rr_arbiter #(
    .num_source_p(NS), .header_width_p(HW), .data_width_p(DW), .max_outstanding_p(MAXO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .msg_header_i(msg_header_i), .msg_data_i(msg_data_i),
    .msg_v_i(msg_v_i), .msg_last_i(msg_last_i), .msg_ready_and_o(msg_ready_and_o),
    .msg_header_o(msg_header_o), .msg_data_o(msg_data_o),
    .msg_v_o(msg_v_o), .msg_last_o(msg_last_o), .msg_ready_and_i(msg_ready_and_i),
    .msg_src_o(msg_src_o), .rev_done_i(rev_done_i), .outstanding_o(outstanding_o)
  );

  function automatic logic [HW-1:0] hdr_f(int s, int t);
    return 64'hA5A5_0000_0000_0000 | 64'(s << 8) | 64'(t);
  endfunction

  function automatic logic [DW-1:0] data_f(int s, int t, int b);
    return 64'hD000_0000_0000_0000 | 64'(s << 16) | 64'(t << 8) | 64'(b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic last, input int t, input int b);
    msg_v_i[s]               = v;
    msg_last_i[s]            = last;
    msg_header_i[s*HW +: HW] = hdr_f(s, t);
    msg_data_i[s*DW +: DW]   = data_f(s, t, b);
  endtask

  task automatic push(input int s, input int t, input int b, input logic last);
    beat_t e;
    e.src  = 1'(s);
    e.hdr  = hdr_f(s, t);
    e.data = data_f(s, t, b);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    rev_done_i = 1'b1;
    repeat (n) tick();
    rev_done_i = 1'b0;
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset_i && msg_v_o && msg_ready_and_i) begin
      beat_t e;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: src %0d hdr %0h with empty queue", msg_src_o, msg_header_o);
      end else begin
        e = exp_q.pop_front();
        chk("beat_src",  64'(msg_src_o),  64'(e.src));
        chk("beat_hdr",  msg_header_o,    e.hdr);
        chk("beat_data", msg_data_o,      e.data);
        chk("beat_last", 64'(msg_last_o), 64'(e.last));
        chk("beat_rdy",  64'(msg_ready_and_o), 64'(2'b01 << e.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; msg_ready_and_i = 1'b1; rev_done_i = 1'b0;
    msg_header_i = '0; msg_data_i = '0;
    msg_v_i = '0; msg_last_i = '0;
    drive(0, 1'b1, 1'b1, 0, 0);
    drive(1, 1'b1, 1'b1, 0, 0);
    tick();
    @(negedge clk);
    chk("reset_v",    64'(msg_v_o), 64'd0);
    chk("reset_rdy",  64'(msg_ready_and_o), 64'd0);
    chk("reset_src",  64'(msg_src_o), 64'd0);
    chk("reset_cnt",  64'(outstanding_o), 64'd0);
    tick();
    reset_i = 1'b0;

    // 1: alternating single-beat grants until credits run out
    drive(0, 1'b1, 1'b1, 1, 0);
    drive(1, 1'b1, 1'b1, 1, 0);
    push(0, 1, 0, 1'b1); push(1, 1, 0, 1'b1); push(0, 1, 0, 1'b1); push(1, 1, 0, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    chk("full_v",   64'(msg_v_o), 64'd0);
    chk("full_cnt", 64'(outstanding_o), 64'd4);

    // 4: retire frees one credit; issue together with retire keeps the count
    rev_done_i = 1'b1;
    tick();
    push(0, 1, 0, 1'b1);
    @(negedge clk);
    chk("retire_cnt", 64'(outstanding_o), 64'd3);
    chk("retire_v",   64'(msg_v_o), 64'd1);
    chk("retire_src", 64'(msg_src_o), 64'd0);
    tick();
    @(negedge clk);
    chk("issue_and_retire_cnt", 64'(outstanding_o), 64'd3);
    msg_v_i = '0;
    drain(3);
    @(negedge clk);
    chk("drain1_cnt", 64'(outstanding_o), 64'd0);

    // Move the pointer back to source 0
    tick();
    drive(1, 1'b1, 1'b1, 2, 0);
    push(1, 2, 0, 1'b1);
    tick();

    // 2: four-beat message from src0 holds the grant against src1
    drive(1, 1'b1, 1'b1, 3, 0);
    for (int b = 0; b < 4; b++) begin
      drive(0, 1'b1, 1'(b == 3), 3, b);
      push(0, 3, b, 1'(b == 3));
      @(negedge clk);
      chk("lock4_src", 64'(msg_src_o), 64'd0);
      tick();
    end
    msg_v_i[0] = 1'b0;
    push(1, 3, 0, 1'b1);
    @(negedge clk);
    chk("after_last_src", 64'(msg_src_o), 64'd1);
    tick();
    msg_v_i = '0;
    @(negedge clk);
    chk("test2_cnt", 64'(outstanding_o), 64'd3);
    drain(3);

    // 3: sink stalls mid-stream; beats neither lost nor duplicated
    drive(0, 1'b1, 1'b0, 4, 0);
    push(0, 4, 0, 1'b0);
    tick();
    drive(0, 1'b1, 1'b0, 4, 1);
    drive(1, 1'b1, 1'b1, 4, 0);
    msg_ready_and_i = 1'b0;
    @(negedge clk);
    chk("stall_src", 64'(msg_src_o), 64'd0);
    chk("stall_rdy", 64'(msg_ready_and_o), 64'd0);
    chk("stall_v",   64'(msg_v_o), 64'd1);
    tick();
    msg_ready_and_i = 1'b1;
    push(0, 4, 1, 1'b0);
    tick();
    drive(0, 1'b1, 1'b1, 4, 2);
    push(0, 4, 2, 1'b1);
    tick();
    msg_v_i[0] = 1'b0;
    push(1, 4, 0, 1'b1);
    tick();
    msg_v_i = '0;
    drain(2);
    @(negedge clk);
    chk("drain3_cnt", 64'(outstanding_o), 64'd0);

    // Pointer to 1 so a cleared pointer is observable after reset
    drive(0, 1'b1, 1'b1, 5, 0);
    push(0, 5, 0, 1'b1);
    tick();

    // 5: reset on beat 2 of a 3-beat message
    drive(0, 1'b1, 1'b0, 6, 0);
    push(0, 6, 0, 1'b0);
    tick();
    drive(0, 1'b1, 1'b0, 6, 1);
    reset_i = 1'b1;
    @(negedge clk);
    chk("midreset_v",   64'(msg_v_o), 64'd0);
    chk("midreset_rdy", 64'(msg_ready_and_o), 64'd0);
    tick();
    reset_i = 1'b0;
    msg_v_i = '0;
    @(negedge clk);
    chk("postreset_v",   64'(msg_v_o), 64'd0);
    chk("postreset_cnt", 64'(outstanding_o), 64'd0);
    tick();
    drive(0, 1'b1, 1'b1, 7, 0);
    drive(1, 1'b1, 1'b1, 7, 0);
    push(0, 7, 0, 1'b1); push(1, 7, 0, 1'b1);
    @(negedge clk);
    chk("postreset_ptr_src", 64'(msg_src_o), 64'd0);
    tick();
    msg_v_i[0] = 1'b0;
    tick();
    msg_v_i = '0;
    drain(2);

    // 6: retire at count zero saturates
    @(negedge clk);
    chk("pre_sat_cnt", 64'(outstanding_o), 64'd0);
    drain(1);
    @(negedge clk);
    chk("sat_cnt", 64'(outstanding_o), 64'd0);

    repeat (2) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
